// File: rtl/wb_hb_master_fifo.sv
// Host-bus to Wishbone classic master bridge with a command FIFO.
// Host commands are queued and issued one at a time. Each Wishbone cycle ends
// on ACK, on ERR, or on a bus timeout. Read results return to the host in order.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | CYC low; pops the next queued command when one is available
// BUSY  | CYC/STB high; waits for ACK/ERR while the timeout counter runs

module wb_hb_master_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int FIFO_AW    = 2,
    parameter int TIMEOUT    = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    hb_req,
    output logic                    hb_ready,
    input  logic                    hb_write,
    input  logic [ADDR_WIDTH-1:0]   hb_addr,
    input  logic [DATA_WIDTH-1:0]   hb_wrData,
    input  logic [DATA_WIDTH/8-1:0] hb_sel,
    output logic                    hb_rdValid,
    output logic [DATA_WIDTH-1:0]   hb_rdData,
    output logic                    hb_error,
    output logic                    hb_timeout,
    output logic                    wb_cycle,
    output logic                    wb_strobe,
    output logic                    wb_write,
    output logic [ADDR_WIDTH-1:0]   wb_addr,
    output logic [DATA_WIDTH-1:0]   wb_wrData,
    output logic [DATA_WIDTH/8-1:0] wb_sel,
    input  logic [DATA_WIDTH-1:0]   wb_rdData,
    input  logic                    wb_ack,
    input  logic                    wb_err
);

    localparam int SW    = DATA_WIDTH / 8;
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int EW    = 1 + ADDR_WIDTH + DATA_WIDTH + SW;
    // A zero-width counter is not legal, so a disabled timeout still keeps one bit.
    localparam int CW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CW-1:0] CNT_LAST = LAST_I[CW-1:0];

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [FIFO_AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [EW-1:0]          fifo_mem [DEPTH];
    logic                   cyc_q, cyc_d;
    logic                   we_q, we_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic [SW-1:0]          sel_q, sel_d;
    logic                   rdv_q, rdv_d;
    logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
    logic                   err_q, err_d;
    logic                   to_q, to_d;
    logic                   empty, full, push, pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                   (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
    // Push only uses the current occupancy, so a full FIFO never accepts a
    // command in the same cycle as a pop.
    assign push  = hb_req && !full;
    assign pop   = (state_q == S_IDLE) && !empty;

    // Store accepted host commands; storage needs no reset because pointers qualify it.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q[FIFO_AW-1:0]] <= {hb_write, hb_addr, hb_wrData, hb_sel};
        end
    end

    // Next-state logic for the FSM, the FIFO pointers and the host pulses.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cyc_d    = cyc_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        sel_d    = sel_q;
        rdv_d    = 1'b0;
        err_d    = 1'b0;
        to_d     = 1'b0;
        rdata_d  = rdata_q;
        wr_ptr_d = wr_ptr_q + {{FIFO_AW{1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{FIFO_AW{1'b0}}, pop};
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    {we_d, addr_d, wdata_d, sel_d} = fifo_mem[rd_ptr_q[FIFO_AW-1:0]];
                    cyc_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (wb_err) begin
                    cyc_d   = 1'b0;
                    err_d   = 1'b1;
                    rdv_d   = !we_q;
                    if (!we_q) rdata_d = '0;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else if (wb_ack) begin
                    cyc_d   = 1'b0;
                    rdv_d   = !we_q;
                    if (!we_q) rdata_d = wb_rdData;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                    cyc_d   = 1'b0;
                    err_d   = 1'b1;
                    to_d    = 1'b1;
                    rdv_d   = !we_q;
                    if (!we_q) rdata_d = '0;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else if (TIMEOUT != 0) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                cyc_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Register the FSM state and every output-facing signal.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cyc_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            sel_q    <= '0;
            rdv_q    <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cyc_q    <= cyc_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            sel_q    <= sel_d;
            rdv_q    <= rdv_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            to_q     <= to_d;
        end
    end

    assign hb_ready   = !full;
    assign hb_rdValid = rdv_q;
    assign hb_rdData  = rdata_q;
    assign hb_error   = err_q;
    assign hb_timeout = to_q;
    // Classic single-beat cycles: STB always tracks CYC.
    assign wb_cycle   = cyc_q;
    assign wb_strobe  = cyc_q;
    assign wb_write   = we_q;
    assign wb_addr    = addr_q;
    assign wb_wrData  = wdata_q;
    assign wb_sel     = sel_q;

endmodule

// File: tb/tb_wb_hb_master_fifo.sv
// Directed bench for wb_hb_master_fifo: a vector table of single commands
// plus hand sequences for FIFO fill, idle ACK/ERR and mid-cycle reset.
`timescale 1ns/1ps
module tb_wb_hb_master_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        hb_req, hb_ready, hb_write;
    logic [15:0] hb_addr, hb_wrData;
    logic [1:0]  hb_sel;
    logic        hb_rdValid, hb_error, hb_timeout;
    logic [15:0] hb_rdData;
    logic        wb_cycle, wb_strobe, wb_write;
    logic [15:0] wb_addr, wb_wrData, wb_rdData;
    logic [1:0]  wb_sel;
    logic        wb_ack, wb_err;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    wb_hb_master_fifo #(
        .DATA_WIDTH(16), .ADDR_WIDTH(16), .FIFO_AW(2), .TIMEOUT(8)
    ) dut (
        .clk(clk), .rst(rst),
        .hb_req(hb_req), .hb_ready(hb_ready), .hb_write(hb_write),
        .hb_addr(hb_addr), .hb_wrData(hb_wrData), .hb_sel(hb_sel),
        .hb_rdValid(hb_rdValid), .hb_rdData(hb_rdData),
        .hb_error(hb_error), .hb_timeout(hb_timeout),
        .wb_cycle(wb_cycle), .wb_strobe(wb_strobe), .wb_write(wb_write),
        .wb_addr(wb_addr), .wb_wrData(wb_wrData), .wb_sel(wb_sel),
        .wb_rdData(wb_rdData), .wb_ack(wb_ack), .wb_err(wb_err)
    );

    // resp: 0 = ACK, 1 = ERR, 2 = ACK+ERR, 3 = no response (timeout)
    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [1:0]  sel;
        int          resp;
        int          dly;
        logic [15:0] sdata;
        logic        exp_rv;
        logic [15:0] exp_rd;
        logic        exp_err;
        logic        exp_to;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input string name);
        int n = 0;
        while (wb_cycle !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(name, {31'd0, wb_cycle}, 32'd1);
    endtask

    // Push n writes (addresses base+k) back to back, honouring hb_ready.
    task automatic push_n(input int n, input logic [15:0] base, output int used);
        int  k   = 0;
        logic acc;
        used = 0;
        hb_write = 1'b1; hb_addr = base; hb_wrData = 16'hC000; hb_sel = 2'b11; hb_req = 1'b1;
        while (k < n && used < 40) begin
            acc = hb_ready;
            @(negedge clk);
            used++;
            if (acc) begin
                k++;
                hb_addr   = base + 16'(k);
                hb_wrData = 16'hC000 + 16'(k);
                if (k == n) hb_req = 1'b0;
            end
        end
        hb_req = 1'b0;
        chk("push_count", k, n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int used;
        vecs[0] = '{1'b1, 16'h0012, 16'hBEEF, 2'b11, 0, 2, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 16'h0040, 16'h0000, 2'b11, 0, 0, 16'h1234, 1'b1, 16'h1234, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 16'h0080, 16'h0000, 2'b11, 3, 0, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b1};
        vecs[3] = '{1'b1, 16'h0100, 16'h1111, 2'b11, 2, 1, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 16'h0200, 16'h0000, 2'b01, 1, 0, 16'hAAAA, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 16'h0300, 16'h0000, 2'b11, 0, 7, 16'h5A5A, 1'b1, 16'h5A5A, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 16'h0004, 16'h7777, 2'b01, 3, 0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[7] = '{1'b1, 16'h0006, 16'h8888, 2'b10, 1, 0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0};

        rst = 1'b1; hb_req = 1'b0; hb_write = 1'b0; hb_addr = '0; hb_wrData = '0; hb_sel = '0;
        wb_rdData = '0; wb_ack = 1'b0; wb_err = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_ready", {31'd0, hb_ready}, 32'd1);
        chk("rst_outs", {hb_rdValid, hb_error, hb_timeout, wb_cycle, wb_strobe, wb_write}, 32'd0);
        chk("rst_bus", {wb_addr, wb_wrData}, 32'd0);
        chk("rst_sel_rd", {wb_sel, hb_rdData}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // ACK/ERR while idle are ignored
        wb_ack = 1'b1; wb_err = 1'b1;
        repeat (2) @(negedge clk);
        wb_ack = 1'b0; wb_err = 1'b0;
        chk("idle_ack_ignored", {hb_rdValid, hb_error, hb_timeout, wb_cycle}, 32'd0);
        @(negedge clk);
        chk("idle_ack_quiet", {hb_rdValid, hb_error, hb_timeout, wb_cycle}, 32'd0);

        // Table-driven single commands
        for (int i = 0; i < 8; i++) begin
            wb_rdData = vecs[i].sdata;
            hb_write = vecs[i].wr; hb_addr = vecs[i].addr;
            hb_wrData = vecs[i].wdata; hb_sel = vecs[i].sel; hb_req = 1'b1;
            @(negedge clk);
            hb_req = 1'b0;
            chk($sformatf("v%0d_cyc_latency", i), {31'd0, wb_cycle}, 32'd0);
            @(negedge clk);
            chk($sformatf("v%0d_cyc_stb", i), {wb_cycle, wb_strobe}, 32'd3);
            chk($sformatf("v%0d_we", i), {31'd0, wb_write}, {31'd0, vecs[i].wr});
            chk($sformatf("v%0d_addr", i), {16'd0, wb_addr}, {16'd0, vecs[i].addr});
            chk($sformatf("v%0d_sel", i), {30'd0, wb_sel}, {30'd0, vecs[i].sel});
            if (vecs[i].wr) chk($sformatf("v%0d_wdata", i), {16'd0, wb_wrData}, {16'd0, vecs[i].wdata});
            if (vecs[i].resp == 3) begin
                repeat (7) begin
                    @(negedge clk);
                    chk($sformatf("v%0d_busy_hold", i), {wb_cycle, hb_error}, 32'd2);
                end
            end else begin
                repeat (vecs[i].dly) @(negedge clk);
                wb_ack = (vecs[i].resp == 0 || vecs[i].resp == 2);
                wb_err = (vecs[i].resp == 1 || vecs[i].resp == 2);
            end
            @(negedge clk);
            wb_ack = 1'b0; wb_err = 1'b0;
            chk($sformatf("v%0d_cyc_end", i), {wb_cycle, wb_strobe}, 32'd0);
            chk($sformatf("v%0d_pulses", i), {hb_rdValid, hb_error, hb_timeout},
                {29'd0, vecs[i].exp_rv, vecs[i].exp_err, vecs[i].exp_to});
            if (vecs[i].exp_rv) chk($sformatf("v%0d_rddata", i), {16'd0, hb_rdData}, {16'd0, vecs[i].exp_rd});
            @(negedge clk);
            chk($sformatf("v%0d_pulse_len", i), {hb_rdValid, hb_error, hb_timeout, wb_cycle}, 32'd0);
        end

        // FIFO fill with a stalled slave, then drain in order
        push_n(5, 16'h1000, used);
        chk("fill_cycles", used, 5);
        chk("fill_not_ready", {31'd0, hb_ready}, 32'd0);
        chk("fill_first_busy", {wb_cycle, 15'd0, wb_addr}, {1'b1, 15'd0, 16'h1000});
        for (int i = 0; i < 5; i++) begin
            wait_cyc($sformatf("drain%0d_cyc", i));
            chk($sformatf("drain%0d_addr", i), {16'd0, wb_addr}, {16'd0, 16'h1000 + 16'(i)});
            chk($sformatf("drain%0d_data", i), {16'd0, wb_wrData}, {16'd0, 16'hC000 + 16'(i)});
            wb_ack = 1'b1;
            @(negedge clk);
            wb_ack = 1'b0;
            chk($sformatf("drain%0d_gap", i), {wb_cycle, hb_error, hb_rdValid}, 32'd0);
        end
        repeat (3) @(negedge clk);
        chk("drain_idle", {wb_cycle, 15'd0, hb_ready}, 32'd1);

        // Reset in the middle of a cycle with three commands queued
        push_n(4, 16'h2000, used);
        chk("rstmid_busy", {31'd0, wb_cycle}, 32'd1);
        chk("rstmid_full_minus", {31'd0, hb_ready}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstmid_cyc", {wb_cycle, wb_strobe}, 32'd0);
        chk("rstmid_ready", {31'd0, hb_ready}, 32'd1);
        chk("rstmid_pulses", {hb_rdValid, hb_error, hb_timeout}, 32'd0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk($sformatf("rstmid_quiet%0d", i), {wb_cycle, wb_strobe, hb_rdValid, hb_error, hb_timeout}, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
